mouse_master_sm: RTL and testbench
==================================

# mouse_master_sm

Master controller for the PS/2 mouse path: drives the byte transmitter to initialise the mouse, then consumes bytes from the byte receiver and assembles standard 3-byte movement packets. Sits directly downstream of the receiver (BYTE_READY/BYTE_READ/BYTE_ERROR_CODE) and upstream of the transceiver's position/button logic, which it notifies with a one-cycle SEND_INTERRUPT per valid packet.

## Interface
- INIT_WAIT, 5_000_000: power-up wait in CLK cycles before the reset command (50 ms at 100 MHz).
- TIMEOUT, 100_000_000: init response timeout in CLK cycles (only used with MOUSE_INIT_WDT_EN).
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high.
- SEND_BYTE  out  1  one-cycle request to transmitter.
- BYTE_TO_SEND  out  8  command byte; valid while SEND_BYTE high, held until next request.
- BYTE_SENT  in  1  transmitter done pulse.
- READ_ENABLE  out  1  enables receiver start-bit detection.
- BYTE_READ  in  8  received byte from receiver.
- BYTE_ERROR_CODE  in  2  [0] parity error, [1] stop-bit error.
- BYTE_READY  in  1  one-cycle received-byte strobe.
- MOUSE_STATUS  out  8  packet byte 1 (buttons, signs, overflow).
- MOUSE_DX  out  8  packet byte 2.
- MOUSE_DY  out  8  packet byte 3.
- SEND_INTERRUPT  out  1  one-cycle pulse: new packet on MOUSE_* outputs.

## Operation
- All outputs registered; reset value 0 for every output; state = WAIT_POWERUP, counters = 0.
- "Good byte" = BYTE_READY high, BYTE_ERROR_CODE == 2'b00, BYTE_READ equals expected value.
- States and transitions:
  - WAIT_POWERUP: count to INIT_WAIT-1 -> SEND_RST.
  - SEND_RST: SEND_BYTE=1, BYTE_TO_SEND=0xFF, 1 cycle -> WAIT_SENT_RST.
  - WAIT_SENT_RST: BYTE_SENT -> WAIT_ACK_RST.
  - WAIT_ACK_RST: good 0xFA -> WAIT_SELFTEST; any other BYTE_READY -> WAIT_POWERUP.
  - WAIT_SELFTEST: good 0xAA -> WAIT_ID; else -> WAIT_POWERUP.
  - WAIT_ID: good 0x00 -> SEND_EN; else -> WAIT_POWERUP.
  - SEND_EN: SEND_BYTE=1, BYTE_TO_SEND=0xF4, 1 cycle -> WAIT_SENT_EN.
  - WAIT_SENT_EN: BYTE_SENT -> WAIT_ACK_EN.
  - WAIT_ACK_EN: good 0xFA -> RX_STATUS; else -> WAIT_POWERUP.
  - RX_STATUS: BYTE_READY, no error, BYTE_READ[3]==1 -> capture, RX_DX; otherwise stay (resync, byte dropped).
  - RX_DX: BYTE_READY, no error -> capture, RX_DY; error -> RX_STATUS (packet dropped).
  - RX_DY: BYTE_READY, no error -> capture, load MOUSE_STATUS/DX/DY from captured bytes, set SEND_INTERRUPT, -> RX_STATUS; error -> RX_STATUS, no interrupt.
- READ_ENABLE = 1 in WAIT_ACK_*, WAIT_SELFTEST, WAIT_ID, RX_*; 0 elsewhere.
- BYTE_READY outside a receiving state ignored.
- MOUSE_* outputs change only on a complete valid packet; hold otherwise.
- Streaming never returns to init except via RESET.
- RESET mid-packet: partial bytes discarded, outputs cleared, init restarts.

## Timing
- SEND_BYTE: exactly one cycle, asserted the cycle after entering SEND_RST/SEND_EN state decision; never re-asserted before BYTE_SENT.
- BYTE_READY sampled on the edge where high; state change visible next cycle.
- Third byte: BYTE_READY high at cycle n -> SEND_INTERRUPT high at n+1 for exactly one cycle; MOUSE_* valid from n+1.
- BYTE_SENT arriving in same cycle as SEND_BYTE ignored (transmitter cannot finish in 0 cycles).
- Power-up wait: SEND_BYTE first high INIT_WAIT+1 cycles after RESET deasserts.

## Configuration
- MOUSE_INIT_WDT_EN defined: 32-bit watchdog counter cleared on every state change; in any init wait state (WAIT_SENT_*, WAIT_ACK_*, WAIT_SELFTEST, WAIT_ID) reaching TIMEOUT-1 -> WAIT_POWERUP. Streaming states never time out.
- Undefined: no watchdog; init wait states wait indefinitely; TIMEOUT unused.

## Test plan
- Normal init: RESET, after INIT_WAIT cycles SEND_BYTE with 0xFF; BYTE_SENT; feed 0xFA,0xAA,0x00 -> SEND_BYTE with 0xF4; BYTE_SENT; feed 0xFA -> READ_ENABLE stays high, state RX_STATUS.
- Packet: feed 0x09, 0x05, 0xFB -> SEND_INTERRUPT one cycle after third BYTE_READY; MOUSE_STATUS=0x09, DX=0x05, DY=0xFB.
- Resync: feed 0x00 (bit3=0) then 0x08,0x01,0x02 -> first byte dropped; one interrupt with STATUS=0x08, DX=0x01, DY=0x02.
- Error mid-packet: 0x08, then 0x10 with BYTE_ERROR_CODE=2'b01 -> no interrupt, outputs unchanged; following 0x28,0x03,0x04 -> interrupt with those values.
- Bad init: reply 0xFC instead of 0xFA -> back to WAIT_POWERUP, 0xFF resent after INIT_WAIT cycles.
- Watchdog (MOUSE_INIT_WDT_EN, TIMEOUT=1000): no BYTE_SENT after 0xFF -> restart after 1000 cycles; without macro, still waiting at 5000 cycles.

Source files
------------

// File: rtl/mouse_master_sm.sv
// mouse_master_sm: PS/2 mouse master controller.
// Initialises the mouse (reset, self-test, device ID, enable data reporting),
// then assembles 3-byte movement packets from the byte receiver and pulses
// SEND_INTERRUPT once per complete, error-free packet.
// Optional init watchdog: define MOUSE_INIT_WDT_EN to return to the power-up
// wait when an init wait state stalls for TIMEOUT cycles.
module mouse_master_sm #(
    parameter int unsigned INIT_WAIT = 5_000_000,
    parameter int unsigned TIMEOUT   = 100_000_000
) (
    input  logic       CLK,
    input  logic       RESET,
    output logic       SEND_BYTE,
    output logic [7:0] BYTE_TO_SEND,
    input  logic       BYTE_SENT,
    output logic       READ_ENABLE,
    input  logic [7:0] BYTE_READ,
    input  logic [1:0] BYTE_ERROR_CODE,
    input  logic       BYTE_READY,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic       SEND_INTERRUPT
);

    typedef enum logic [3:0] {
        StWaitPowerup,
        StSendRst,
        StWaitSentRst,
        StWaitAckRst,
        StWaitSelftest,
        StWaitId,
        StSendEn,
        StWaitSentEn,
        StWaitAckEn,
        StRxStatus,
        StRxDx,
        StRxDy
    } state_e;

    localparam logic [7:0] CmdReset  = 8'hFF;
    localparam logic [7:0] CmdEnable = 8'hF4;
    localparam logic [7:0] RspAck    = 8'hFA;
    localparam logic [7:0] RspPass   = 8'hAA;
    localparam logic [7:0] RspId     = 8'h00;

    state_e      state_q, state_d;
    logic [31:0] cnt_q;
    logic [7:0]  status_q, dx_q;
    logic        cap_status, cap_dx, pkt_done;
    logic        byte_ok;

    // A received byte with clean parity and stop bit.
    assign byte_ok = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);

    function automatic logic is_rx_state(input state_e s);
        return (s == StWaitAckRst) || (s == StWaitSelftest) || (s == StWaitId) ||
               (s == StWaitAckEn) || (s == StRxStatus) || (s == StRxDx) || (s == StRxDy);
    endfunction

`ifdef MOUSE_INIT_WDT_EN
    logic [31:0] wdt_q;

    function automatic logic is_init_wait(input state_e s);
        return (s == StWaitSentRst) || (s == StWaitSentEn) || (s == StWaitAckRst) ||
               (s == StWaitAckEn) || (s == StWaitSelftest) || (s == StWaitId);
    endfunction

    // Watchdog restarts on every state change.
    always_ff @(posedge CLK) begin
        if (RESET || (state_d != state_q)) wdt_q <= '0;
        else                               wdt_q <= wdt_q + 32'd1;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Next-state decode and packet-capture strobes.
    always_comb begin
        state_d    = state_q;
        cap_status = 1'b0;
        cap_dx     = 1'b0;
        pkt_done   = 1'b0;
        case (state_q)
            StWaitPowerup: if (cnt_q == 32'(INIT_WAIT - 1)) state_d = StSendRst;
            StSendRst:     state_d = StWaitSentRst;
            // A done pulse coincident with our own request cannot be genuine.
            StWaitSentRst: if (BYTE_SENT && !SEND_BYTE) state_d = StWaitAckRst;
            StWaitAckRst: begin
                if (BYTE_READY) begin
                    state_d = (byte_ok && BYTE_READ == RspAck) ? StWaitSelftest : StWaitPowerup;
                end
            end
            StWaitSelftest: begin
                if (BYTE_READY) begin
                    state_d = (byte_ok && BYTE_READ == RspPass) ? StWaitId : StWaitPowerup;
                end
            end
            StWaitId: begin
                if (BYTE_READY) begin
                    state_d = (byte_ok && BYTE_READ == RspId) ? StSendEn : StWaitPowerup;
                end
            end
            StSendEn:     state_d = StWaitSentEn;
            StWaitSentEn: if (BYTE_SENT && !SEND_BYTE) state_d = StWaitAckEn;
            StWaitAckEn: begin
                if (BYTE_READY) begin
                    state_d = (byte_ok && BYTE_READ == RspAck) ? StRxStatus : StWaitPowerup;
                end
            end
            // Bit 3 of the status byte is always set; use it to resync.
            StRxStatus: begin
                if (byte_ok && BYTE_READ[3]) begin
                    cap_status = 1'b1;
                    state_d    = StRxDx;
                end
            end
            StRxDx: begin
                if (BYTE_READY) begin
                    if (byte_ok) begin
                        cap_dx  = 1'b1;
                        state_d = StRxDy;
                    end else begin
                        state_d = StRxStatus;
                    end
                end
            end
            StRxDy: begin
                if (BYTE_READY) begin
                    pkt_done = byte_ok;
                    state_d  = StRxStatus;
                end
            end
            default: state_d = StWaitPowerup;
        endcase
`ifdef MOUSE_INIT_WDT_EN
        if (is_init_wait(state_q) && (state_d == state_q) && (wdt_q == 32'(TIMEOUT - 1))) begin
            state_d = StWaitPowerup;
        end
`endif
    end

    // State register and power-up counter (held at zero outside the wait).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StWaitPowerup;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StWaitPowerup && state_d == StWaitPowerup) cnt_q <= cnt_q + 32'd1;
            else                                                      cnt_q <= '0;
        end
    end

    // Partial-packet capture of the first two bytes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            status_q <= '0;
            dx_q     <= '0;
        end else begin
            if (cap_status) status_q <= BYTE_READ;
            if (cap_dx)     dx_q     <= BYTE_READ;
        end
    end

    // Registered outputs: transmit requests, receive enable, packet results.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            SEND_BYTE      <= 1'b0;
            BYTE_TO_SEND   <= '0;
            READ_ENABLE    <= 1'b0;
            MOUSE_STATUS   <= '0;
            MOUSE_DX       <= '0;
            MOUSE_DY       <= '0;
            SEND_INTERRUPT <= 1'b0;
        end else begin
            SEND_BYTE      <= (state_q == StSendRst) || (state_q == StSendEn);
            if (state_q == StSendRst) BYTE_TO_SEND <= CmdReset;
            if (state_q == StSendEn)  BYTE_TO_SEND <= CmdEnable;
            READ_ENABLE    <= is_rx_state(state_d);
            SEND_INTERRUPT <= pkt_done;
            if (pkt_done) begin
                MOUSE_STATUS <= status_q;
                MOUSE_DX     <= dx_q;
                MOUSE_DY     <= BYTE_READ;
            end
        end
    end

endmodule

// File: tb/tb_mouse_master_sm.sv
// Directed self-checking bench for mouse_master_sm.
module tb_mouse_master_sm;

    localparam int unsigned InitWait = 20;
    localparam int unsigned Timeout  = 1000;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT = 1'b0;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ = 8'h00;
    logic [1:0] BYTE_ERROR_CODE = 2'b00;
    logic       BYTE_READY = 1'b0;
    logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY;
    logic       SEND_INTERRUPT;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n;

    mouse_master_sm #(
        .INIT_WAIT(InitWait),
        .TIMEOUT  (Timeout)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .SEND_BYTE      (SEND_BYTE),
        .BYTE_TO_SEND   (BYTE_TO_SEND),
        .BYTE_SENT      (BYTE_SENT),
        .READ_ENABLE    (READ_ENABLE),
        .BYTE_READ      (BYTE_READ),
        .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
        .BYTE_READY     (BYTE_READY),
        .MOUSE_STATUS   (MOUSE_STATUS),
        .MOUSE_DX       (MOUSE_DX),
        .MOUSE_DY       (MOUSE_DY),
        .SEND_INTERRUPT (SEND_INTERRUPT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic feed(input logic [7:0] b, input logic [1:0] err);
        BYTE_READ       = b;
        BYTE_ERROR_CODE = err;
        BYTE_READY      = 1'b1;
        tick();
        BYTE_READY      = 1'b0;
        BYTE_ERROR_CODE = 2'b00;
    endtask

    task automatic pulse_sent();
        BYTE_SENT = 1'b1;
        tick();
        BYTE_SENT = 1'b0;
    endtask

    // Cycles until SEND_BYTE rises, bounded.
    task automatic wait_send(input int unsigned limit, output int unsigned cnt);
        cnt = 0;
        while (!SEND_BYTE && cnt < limit) begin
            tick();
            cnt++;
        end
    endtask

    task automatic check_pkt(input string tag, input logic [7:0] s, input logic [7:0] x,
                             input logic [7:0] y, input logic irq);
        check({tag, "_irq"}, 32'(SEND_INTERRUPT), 32'(irq));
        check({tag, "_status"}, 32'(MOUSE_STATUS), 32'(s));
        check({tag, "_dx"}, 32'(MOUSE_DX), 32'(x));
        check({tag, "_dy"}, 32'(MOUSE_DY), 32'(y));
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_send", 32'(SEND_BYTE), 32'd0);
        check("rst_tx", 32'(BYTE_TO_SEND), 32'd0);
        check("rst_ren", 32'(READ_ENABLE), 32'd0);
        check_pkt("rst", 8'h00, 8'h00, 8'h00, 1'b0);
        RESET = 1'b0;

        // Normal init
        wait_send(200, n);
        check("pwrup_wait", n, InitWait + 1);
        check("tx_ff", 32'(BYTE_TO_SEND), 32'hFF);
        BYTE_SENT = 1'b1;  // coincident with SEND_BYTE: must be ignored
        tick();
        BYTE_SENT = 1'b0;
        check("send_one_cycle", 32'(SEND_BYTE), 32'd0);
        check("sent_ignored", 32'(READ_ENABLE), 32'd0);
        feed(8'hFA, 2'b00);  // not receiving yet: ignored
        check("early_byte_ren", 32'(READ_ENABLE), 32'd0);
        pulse_sent();
        check("ack_rst_ren", 32'(READ_ENABLE), 32'd1);
        feed(8'hFA, 2'b00);
        feed(8'hAA, 2'b00);
        feed(8'h00, 2'b00);
        check("send_en_ren", 32'(READ_ENABLE), 32'd0);
        wait_send(5, n);
        check("en_send", 32'(SEND_BYTE), 32'd1);
        check("tx_f4", 32'(BYTE_TO_SEND), 32'hF4);
        tick();
        pulse_sent();
        feed(8'hFA, 2'b00);
        check("stream_ren", 32'(READ_ENABLE), 32'd1);
        check("stream_irq", 32'(SEND_INTERRUPT), 32'd0);

        // Packet
        feed(8'h09, 2'b00);
        feed(8'h05, 2'b00);
        check_pkt("pkt1_partial", 8'h00, 8'h00, 8'h00, 1'b0);
        feed(8'hFB, 2'b00);
        check_pkt("pkt1", 8'h09, 8'h05, 8'hFB, 1'b1);
        tick();
        check_pkt("pkt1_hold", 8'h09, 8'h05, 8'hFB, 1'b0);

        // Resync on a status byte with bit 3 clear
        feed(8'h00, 2'b00);
        feed(8'h08, 2'b00);
        feed(8'h01, 2'b00);
        check("resync_noirq", 32'(SEND_INTERRUPT), 32'd0);
        feed(8'h02, 2'b00);
        check_pkt("resync", 8'h08, 8'h01, 8'h02, 1'b1);

        // Parity error on the second byte
        feed(8'h08, 2'b00);
        feed(8'h10, 2'b01);
        check_pkt("err_dx", 8'h08, 8'h01, 8'h02, 1'b0);
        feed(8'h28, 2'b00);
        feed(8'h03, 2'b00);
        feed(8'h04, 2'b00);
        check_pkt("after_err", 8'h28, 8'h03, 8'h04, 1'b1);

        // Stop-bit error on the third byte
        feed(8'h18, 2'b00);
        feed(8'h11, 2'b00);
        feed(8'h12, 2'b10);
        check_pkt("err_dy", 8'h28, 8'h03, 8'h04, 1'b0);
        check("err_dy_ren", 32'(READ_ENABLE), 32'd1);

        // Reset mid-packet clears outputs and restarts init
        feed(8'h08, 2'b00);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check_pkt("midpkt_rst", 8'h00, 8'h00, 8'h00, 1'b0);
        check("midpkt_rst_ren", 32'(READ_ENABLE), 32'd0);

        // Bad init reply
        wait_send(200, n);
        check("pwrup_wait2", n, InitWait + 1);
        tick();
        pulse_sent();
        feed(8'hFC, 2'b00);
        check("bad_ack_ren", 32'(READ_ENABLE), 32'd0);
        wait_send(200, n);
        check("bad_ack_retry", n, InitWait + 1);
        check("bad_ack_tx", 32'(BYTE_TO_SEND), 32'hFF);

        // Transmitter never finishes
        tick();
`ifdef MOUSE_INIT_WDT_EN
        wait_send(3000, n);
        check("wdt_restart", n, Timeout + InitWait);
        check("wdt_tx", 32'(BYTE_TO_SEND), 32'hFF);
`else
        wait_send(5000, n);
        check("no_wdt_wait", n, 32'd5000);
        check("no_wdt_send", 32'(SEND_BYTE), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
